obstacle_scheduler: RTL
=======================

# obstacle_scheduler

Parametrised obstacle-slot scheduler for the runner game: owns a circular queue of `SLOTS` obstacle instances and decides when to spawn and which type. On every game update it also retires off-screen obstacles. It sits between the game-state controller and the bank of `obstacle` instances, and generalises the fixed 7-slot horizon logic. Additions:

- configurable slot/type counts and duplication limit;
- per-type enable mask and minimum-speed table;
- full-queue protection and an occupancy count;
- multi-slot retirement per update;
- restart from the crashed state without reset.

## Interface

Parameters:
- `SLOTS`, 7: obstacle slots in the ring (≥2).
- `TYPES`, 3: obstacle types. Type codes are 1..TYPES; 0 = none.
- `MAX_DUP`, 2: maximum consecutive identical types.
- `GAME_WIDTH`, 600: spawn threshold in pixels.
- `XW`, 11: signed x-position width.
- `SPEED_W`, 15: speed width.

Derived widths: IW = $clog2(SLOTS), CW = $clog2(SLOTS+1), TW = $clog2(TYPES+1).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin or restart the run.
- `crash` in 1: freeze scheduling.
- `update` in 1: one-cycle game-tick pulse.
- `enable` in 1: permit spawning.
- `speed` in SPEED_W: current speed, unsigned.
- `rng` in 11: random word, sampled in SPAWN.
- `type_en` in TYPES: bit k enables type k+1.
- `min_speed` in TYPES*SPEED_W: packed; field k is the minimum speed for type k+1.
- `slot_visible` in SLOTS: per-slot visible flag.
- `slot_remove` in SLOTS: per-slot "left screen" flag.
- `slot_x` in SLOTS*XW: signed x per slot.
- `slot_width` in SLOTS*10: width per slot.
- `slot_gap` in SLOTS*11: gap per slot.
- `slot_update` out 1: obstacle update strobe.
- `slot_start` out SLOTS: slot active.
- `slot_type` out SLOTS*TW: type per slot.
- `front` out IW: oldest occupied slot. Drives collision-box selection.
- `count` out CW: occupied slots.
- `busy` out 1: high in SPAWN, SETTLE and REAP.

## Operation

Queue:
- `front` and `back` index the ring; `count` is held explicitly.
- Increment/decrement wrap modulo SLOTS.
- The last entry is back−1 (mod SLOTS).
- Empty is count==0; full is count==SLOTS.

State machine:
- IDLE →RUN on `start`.
- RUN →HALT on `crash`, else →SPAWN on `update`.
- SPAWN →SETTLE unconditionally.
- SETTLE →REAP unconditionally.
- REAP stays in REAP while count>0 and slot_remove[front]; otherwise →RUN.
- HALT →RUN on `start`. In the same cycle the queue is cleared: all slot_start=0, slot_type=0, front=back=count=0.
- `crash` has priority over every transition except `rst`: from SPAWN, SETTLE or REAP the next state is HALT, and no spawn or retire occurs in that cycle.

SPAWN:
- Pulse slot_update=1.
- Spawn condition: enable && !full && (empty || (slot_visible[last] && slot_x[last]+width[last]+gap[last] < GAME_WIDTH)).
- The sum is evaluated signed at XW+2 bits.
- Type search: for i=0..TYPES-1, candidate = ((rng+i) mod TYPES)+1. Take the first candidate that passes all three checks:
  - type_en[candidate-1];
  - speed ≥ min_speed[candidate-1];
  - not a duplicate. A candidate is a duplicate when count ≥ MAX_DUP and the last MAX_DUP queued types all equal the candidate.
- If no candidate passes, nothing is spawned.
- On spawn: slot_type[back] ← candidate, slot_start[back] ← 1, back++, count++.

REAP: each cycle with count>0 and slot_remove[front]:
- slot_start[front] ← 0 and slot_type[front] ← 0;
- front++, count−−.
- Exactly one slot is retired per cycle.

An `update` arriving while busy is ignored.

## Timing

- Reset values: state IDLE; slot_update=0, slot_start all 0, slot_type all 0, front=0, count=0, busy=0.
- All outputs are registered.
- slot_update is high for exactly one cycle, the cycle after `update` is sampled in RUN.
- A new slot_start rises in that same cycle.
- Minimum update-to-RUN latency is 3 cycles (SPAWN, SETTLE, REAP×1). Add one cycle per retired slot beyond the first check.
- Full queue: the spawn is suppressed and count stays SLOTS.
- Wrap-around: back and front pass from SLOTS−1 to 0.
- `rst` mid-REAP returns all outputs to their reset values on the next edge.

## Test plan

- Reset, start, enable=1, type_en=all, min_speed=0, rng=0, one update → slot_update pulse, slot_start[0]=1, slot_type[0]=1, count=1, back=1.
- Last slot x=500, width=20, gap=100 (sum 620 ≥ 600) → no spawn. Change x to 400 (sum 520) → spawn into the next slot.
- Force rng=0 repeatedly with MAX_DUP=2 → third type is 2, not 1. With type_en=3'b001 → no third spawn, count stays 2.
- Fill all SLOTS with slot_remove=0 → count=SLOTS, further updates spawn nothing. Then assert slot_remove on the front 3 slots → 3 REAP cycles, count=SLOTS−3, front=3.
- Drive the ring past index SLOTS−1 → back wraps to 0 and type indexing stays correct.
- Assert crash during SETTLE → HALT next cycle, queue unchanged. Then start → all slot_start=0, count=0, state RUN.

Source files
------------

// File: rtl/obstacle_scheduler.sv
// Purpose : ring scheduler for SLOTS obstacle instances; decides spawn/type on a
//           game tick and retires off-screen slots from the front of the ring.
// Latency : slot_update/slot_start one cycle after update; back in RUN >= 3 cycles
//           later, plus one cycle per retired slot.
// Backpr. : no handshake; an update arriving while busy is dropped, and a full
//           ring suppresses the spawn.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             begin a run from IDLE, or restart (and clear) from HALT
//   crash             freeze scheduling; wins over every transition except rst
//   update            one-cycle game tick, honoured only in RUN
//   enable            permit spawning
//   speed             current game speed (unsigned)
//   rng               random word used to pick the first candidate type
//   type_en           bit k enables type k+1
//   min_speed         packed; field k is the minimum speed for type k+1
//   slot_visible      per-slot visible flag from the obstacle bank
//   slot_remove       per-slot "left the screen" flag from the obstacle bank
//   slot_x            per-slot signed x position
//   slot_width        per-slot width
//   slot_gap          per-slot gap requested behind the obstacle
//   slot_update       one-cycle strobe telling the obstacle bank to advance
//   slot_start        per-slot active flag
//   slot_type         per-slot type code (0 = none)
//   front             index of the oldest occupied slot
//   count             number of occupied slots
//   busy              high while in SPAWN, SETTLE or REAP
module obstacle_scheduler #(
  parameter int SLOTS      = 7,
  parameter int TYPES      = 3,
  parameter int MAX_DUP    = 2,
  parameter int GAME_WIDTH = 600,
  parameter int XW         = 11,
  parameter int SPEED_W    = 15,
  localparam int IW        = $clog2(SLOTS),
  localparam int CW        = $clog2(SLOTS + 1),
  localparam int TW        = $clog2(TYPES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     crash,
  input  logic                     update,
  input  logic                     enable,
  input  logic [SPEED_W-1:0]       speed,
  input  logic [10:0]              rng,
  input  logic [TYPES-1:0]         type_en,
  input  logic [TYPES*SPEED_W-1:0] min_speed,
  input  logic [SLOTS-1:0]         slot_visible,
  input  logic [SLOTS-1:0]         slot_remove,
  input  logic [SLOTS*XW-1:0]      slot_x,
  input  logic [SLOTS*10-1:0]      slot_width,
  input  logic [SLOTS*11-1:0]      slot_gap,
  output logic                     slot_update,
  output logic [SLOTS-1:0]         slot_start,
  output logic [SLOTS*TW-1:0]      slot_type,
  output logic [IW-1:0]            front,
  output logic [CW-1:0]            count,
  output logic                     busy
);

  // Position sum is done two bits wider than x so x+width+gap cannot wrap.
  localparam int SW = XW + 2;
  localparam logic signed [SW-1:0] GW_S = SW'(GAME_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SPAWN,
    S_SETTLE,
    S_REAP,
    S_HALT
  } state_t;

  state_t              state_q;
  logic                slot_update_q;
  logic                busy_q;
  logic [SLOTS-1:0]    slot_start_q;
  logic [TW-1:0]       slot_type_q [SLOTS];
  logic [IW-1:0]       front_q;
  logic [IW-1:0]       back_q;
  logic [CW-1:0]       count_q;

  // ---------------------------------------------------------------------------
  // Ring helpers
  // ---------------------------------------------------------------------------
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(SLOTS - 1)) ? '0 : v + IW'(1);
  endfunction

  logic [IW-1:0] last_d;
  logic          empty_d;
  logic          full_d;

  always_comb begin
    last_d  = (back_q == '0) ? IW'(SLOTS - 1) : back_q - IW'(1);
    empty_d = (count_q == '0);
    full_d  = (count_q == CW'(SLOTS));
  end

  // ---------------------------------------------------------------------------
  // Spacing check against the most recently spawned obstacle
  // ---------------------------------------------------------------------------
  logic [XW-1:0] last_x_d;
  logic [9:0]    last_w_d;
  logic [10:0]   last_g_d;
  logic          last_vis_d;
  logic [SW-1:0] pos_sum_d;
  logic          gap_ok_d;

  always_comb begin
    last_x_d   = '0;
    last_w_d   = '0;
    last_g_d   = '0;
    last_vis_d = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      if (IW'(k) == last_d) begin
        last_x_d   = slot_x[k*XW +: XW];
        last_w_d   = slot_width[k*10 +: 10];
        last_g_d   = slot_gap[k*11 +: 11];
        last_vis_d = slot_visible[k];
      end
    end
    // x is signed; width and gap are magnitudes.
    pos_sum_d = {{2{last_x_d[XW-1]}}, last_x_d}
              + {{(SW-10){1'b0}}, last_w_d}
              + {{(SW-11){1'b0}}, last_g_d};
    gap_ok_d  = empty_d || (last_vis_d && ($signed(pos_sum_d) < GW_S));
  end

  // ---------------------------------------------------------------------------
  // Type search: rotate through types starting at rng mod TYPES, take the
  // first one that is enabled, fast enough, and would not extend a run of
  // MAX_DUP identical types.
  // ---------------------------------------------------------------------------
  int                 base_d;
  int                 cand_d;
  logic               is_dup_d;
  logic               en_bit_d;
  logic [SPEED_W-1:0] min_spd_d;
  logic [IW-1:0]      hist_idx_d;
  logic               cand_found_d;
  logic [TW-1:0]      cand_type_d;
  logic               do_spawn_d;

  always_comb begin
    base_d       = int'(rng) % TYPES;
    cand_d       = 0;
    is_dup_d     = 1'b0;
    en_bit_d     = 1'b0;
    min_spd_d    = '0;
    hist_idx_d   = '0;
    cand_found_d = 1'b0;
    cand_type_d  = '0;
    for (int i = 0; i < TYPES; i++) begin
      cand_d    = (base_d + i) % TYPES;
      en_bit_d  = 1'b0;
      min_spd_d = '0;
      for (int t = 0; t < TYPES; t++) begin
        if (t == cand_d) begin
          en_bit_d  = type_en[t];
          min_spd_d = min_speed[t*SPEED_W +: SPEED_W];
        end
      end
      // History walks back from back-1; only meaningful once MAX_DUP are queued.
      is_dup_d = (int'(count_q) >= MAX_DUP);
      for (int j = 1; j <= MAX_DUP; j++) begin
        hist_idx_d = IW'((int'(back_q) + SLOTS - j) % SLOTS);
        if (slot_type_q[hist_idx_d] != TW'(cand_d + 1)) begin
          is_dup_d = 1'b0;
        end
      end
      if (!cand_found_d && en_bit_d && (speed >= min_spd_d) && !is_dup_d) begin
        cand_found_d = 1'b1;
        cand_type_d  = TW'(cand_d + 1);
      end
    end
    do_spawn_d = enable && !full_d && gap_ok_d && cand_found_d;
  end

  // ---------------------------------------------------------------------------
  // Controller. The spawn decision is taken on the RUN->SPAWN edge so that the
  // new slot_start rises together with the slot_update strobe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      slot_update_q <= 1'b0;
      busy_q        <= 1'b0;
      slot_start_q  <= '0;
      front_q       <= '0;
      back_q        <= '0;
      count_q       <= '0;
      for (int k = 0; k < SLOTS; k++) begin
        slot_type_q[k] <= '0;
      end
    end else begin
      slot_update_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !crash) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (crash) begin
            state_q <= S_HALT;
          end else if (update) begin
            state_q       <= S_SPAWN;
            slot_update_q <= 1'b1;
            busy_q        <= 1'b1;
            if (do_spawn_d) begin
              slot_start_q[back_q] <= 1'b1;
              slot_type_q[back_q]  <= cand_type_d;
              back_q               <= wrap_inc(back_q);
              count_q              <= count_q + CW'(1);
            end
          end
        end
        S_SPAWN: begin
          if (crash) begin
            state_q <= S_HALT;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (crash) begin
            state_q <= S_HALT;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_REAP;
          end
        end
        S_REAP: begin
          if (crash) begin
            state_q <= S_HALT;
            busy_q  <= 1'b0;
          end else if ((count_q != '0) && slot_remove[front_q]) begin
            // One retirement per cycle; stay here to re-check the new front.
            slot_start_q[front_q] <= 1'b0;
            slot_type_q[front_q]  <= '0;
            front_q               <= wrap_inc(front_q);
            count_q               <= count_q - CW'(1);
          end else begin
            state_q <= S_RUN;
            busy_q  <= 1'b0;
          end
        end
        S_HALT: begin
          if (start && !crash) begin
            state_q      <= S_RUN;
            slot_start_q <= '0;
            front_q      <= '0;
            back_q       <= '0;
            count_q      <= '0;
            for (int k = 0; k < SLOTS; k++) begin
              slot_type_q[k] <= '0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_type = '0;
    for (int k = 0; k < SLOTS; k++) begin
      slot_type[k*TW +: TW] = slot_type_q[k];
    end
  end

  assign slot_update = slot_update_q;
  assign slot_start  = slot_start_q;
  assign front       = front_q;
  assign count       = count_q;
  assign busy        = busy_q;

endmodule
